add_serial_ctrl: RTL and testbench

ADD_SERIAL_CTRL -- requirements
Module: add_serial_ctrl

---
 rtl/add_serial_ctrl.sv | 145 ++++++++++++++
 tb/tb_add_serial_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl: bit-serial adder/subtractor controller.
// Adds a + b + ci one bit per clock, LSB first, through a single 1-bit
// full adder (add1). The result is published on sum/co together with a
// one-cycle done pulse and held until the next result is published.
// Optional feature macro: ADD_SERIAL_SUB_EN enables a - b when sub=1 at
// accept (b is inverted and the carry-in forced to 1; co=1 means no borrow).
// Without the macro the sub input is ignored and only addition is done.

// 1-bit full adder: the only arithmetic element of the serial datapath.
module add1 (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module add_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is a request with no ready signal; it is accepted on a
  // rising edge only while the FSM is in IDLE or DONE and is silently
  // dropped during RUN. busy (registered, one cycle behind the FSM) covers
  // the WIDTH bit cycles; done pulses for exactly one cycle when sum/co
  // take the new result.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic               carry_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, co_q;
  logic [WIDTH-1:0]   sum_q;

  logic [WIDTH-1:0]   a_d, b_d, res_d;
  logic [CW-1:0]      cnt_d;
  logic               fa_s, fa_co;
  logic [WIDTH-1:0]   b_in;
  logic               ci_in;

`ifdef ADD_SERIAL_SUB_EN
  // Subtraction as a + ~b + 1; the external carry-in is overridden.
  assign b_in  = sub ? ~b : b;
  assign ci_in = sub ? 1'b1 : ci;
`else
  logic sub_unused;
  assign b_in       = b;
  assign ci_in      = ci;
  assign sub_unused = sub;
`endif

  add1 u_add1 (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Next values for one serial step: shift operands right, sum bit enters at the MSB.
  always_comb begin
    a_d   = a_q >> 1;
    b_d   = b_q >> 1;
    res_d = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    cnt_d = cnt_q + CW'(1);
  end

  // Control FSM with registered busy/done/sum/co outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      busy_q <= (state_q == RUN);
      done_q <= (state_q == DONE);
      if (state_q == DONE) begin
        sum_q <= res_q;
        co_q  <= carry_q;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= ci_in;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          res_q   <= res_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_d;
          if (cnt_q == LAST) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sum         = sum_q;
  assign co          = co_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Testbench for add_serial_ctrl: a WIDTH=8 instance for the directed
// arithmetic/timing/reset scenarios and a WIDTH=1 instance for the
// back-to-back full-adder truth table. Expected values are hand-computed.
module tb_add_serial_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, ci8, sub8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;

  logic       start1, ci1, sub1, busy1, done1, co1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] st1;

  int n_cmp;
  int n_fail;

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  add_serial_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .sub(sub8), .busy(busy8), .done(done8), .sum(sum8), .co(co8),
    .dbg_state_o(st8)
  );

  add_serial_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .sub(sub1), .busy(busy1), .done(done1), .sum(sum1), .co(co1),
    .dbg_state_o(st1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // capture every result pulse of the 1-bit instance
  always @(negedge clk) begin
    if (done1 === 1'b1) got_q.push_back({co1, sum1});
  end

  // driver: call just after a rising edge; runs one operation on dut8
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sub,
                         output logic [7:0] s, output logic c,
                         output int nbusy, output int first_busy,
                         output int done_at, output int ndone,
                         output bit stable);
    logic [7:0] prev_s;
    logic       prev_c;
    start8 = 1'b1; a8 = a; b8 = b; ci8 = ci; sub8 = sub;
    @(posedge clk); #1;
    start8 = 1'b0;
    prev_s = sum8; prev_c = co8;
    s = 8'hxx; c = 1'bx;
    nbusy = 0; first_busy = -1; done_at = -1; ndone = 0; stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy8 === 1'b1) begin
        nbusy++;
        if (first_busy < 0) first_busy = i;
        if (sum8 !== prev_s || co8 !== prev_c) stable = 1'b0;
      end
      if (done8 === 1'b1) begin
        ndone++;
        if (done_at < 0) begin done_at = i; s = sum8; c = co8; end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8: got %b expected 0", done8); end
    n_cmp++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum8: got %h expected 00", sum8); end
    n_cmp++; if (co8 !== 1'b0) begin n_fail++; $display("FAIL reset_co8: got %b expected 0", co8); end
    n_cmp++; if (st8 !== 2'd0) begin n_fail++; $display("FAIL reset_state8: got %0d expected 0", st8); end
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b expected 0", done1); end
    n_cmp++; if ({co1, sum1} !== 2'b00) begin n_fail++; $display("FAIL reset_res1: got %b expected 00", {co1, sum1}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    logic [7:0] s; logic c; int nb, fb, da, nd; bit st;
    @(posedge clk); #1;
    run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, s, c, nb, fb, da, nd, st);
    n_cmp++; if (s !== 8'h96) begin n_fail++; $display("FAIL basic_sum: got %h expected 96", s); end
    n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL basic_co: got %b expected 0", c); end
    n_cmp++; if (nb != 8) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected 8", nb); end
    n_cmp++; if (fb != 1) begin n_fail++; $display("FAIL basic_busy_start: got %0d expected 1", fb); end
    n_cmp++; if (da != 9) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 9", da); end
    n_cmp++; if (nd != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
    n_cmp++; if (st != 1'b1) begin n_fail++; $display("FAIL basic_sum_stable: got %b expected 1", st); end
  endtask

  task automatic test_carry();
    logic [7:0] s; logic c; int nb, fb, da, nd; bit st;
    @(posedge clk); #1;
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0, s, c, nb, fb, da, nd, st);
    n_cmp++; if (s !== 8'h00) begin n_fail++; $display("FAIL carry1_sum: got %h expected 00", s); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL carry1_co: got %b expected 1", c); end
    @(posedge clk); #1;
    run_op8(8'hFF, 8'hFF, 1'b1, 1'b0, s, c, nb, fb, da, nd, st);
    n_cmp++; if (s !== 8'hFF) begin n_fail++; $display("FAIL carry2_sum: got %h expected ff", s); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL carry2_co: got %b expected 1", c); end
    n_cmp++; if (st != 1'b1) begin n_fail++; $display("FAIL carry2_sum_stable: got %b expected 1", st); end
    @(posedge clk); #1;
    run_op8(8'h00, 8'h00, 1'b1, 1'b0, s, c, nb, fb, da, nd, st);
    n_cmp++; if ({c, s} !== 9'h001) begin n_fail++; $display("FAIL carry3_res: got %h expected 001", {c, s}); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] s; logic c; int nd, da;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; ci8 = 1'b0; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    @(posedge clk); #1;
    start8 = 1'b0;
    nd = 0; da = -1; s = 8'hxx; c = 1'bx;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        nd++;
        if (da < 0) begin da = i; s = sum8; c = co8; end
      end
    end
    n_cmp++; if (s !== 8'h96) begin n_fail++; $display("FAIL ignore_sum: got %h expected 96", s); end
    n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL ignore_co: got %b expected 0", c); end
    n_cmp++; if (nd != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    n_cmp++; if (da != 5) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected 5", da); end
  endtask

  task automatic test_reset_mid_run();
    int nd, nb;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done8); end
    n_cmp++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL midrst_sum: got %h expected 00", sum8); end
    n_cmp++; if (co8 !== 1'b0) begin n_fail++; $display("FAIL midrst_co: got %b expected 0", co8); end
    n_cmp++; if (st8 !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", st8); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) nd++;
      if (busy8 === 1'b1) nb++;
    end
    n_cmp++; if (nd != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", nd); end
    n_cmp++; if (nb != 0) begin n_fail++; $display("FAIL midrst_no_busy: got %0d expected 0", nb); end
  endtask

  task automatic test_start_after_reset();
    logic [7:0] s; logic c; int nb, fb, da, nd; bit st;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op8(8'h21, 8'h43, 1'b1, 1'b0, s, c, nb, fb, da, nd, st);
    n_cmp++; if ({c, s} !== 9'h065) begin n_fail++; $display("FAIL post_rst_res: got %h expected 065", {c, s}); end
    n_cmp++; if (da != 9) begin n_fail++; $display("FAIL post_rst_done_cycle: got %0d expected 9", da); end
  endtask

  task automatic test_sub();
    logic [7:0] s; logic c; int nb, fb, da, nd; bit st;
    logic [8:0] e1, e2;
`ifdef ADD_SERIAL_SUB_EN
    e1 = 9'h10F; e2 = 9'h0FF;
`else
    e1 = 9'h011; e2 = 9'h003;
`endif
    @(posedge clk); #1;
    run_op8(8'h10, 8'h01, 1'b0, 1'b1, s, c, nb, fb, da, nd, st);
    n_cmp++; if ({c, s} !== e1) begin n_fail++; $display("FAIL sub1_res: got %h expected %h", {c, s}, e1); end
    @(posedge clk); #1;
    run_op8(8'h01, 8'h02, 1'b0, 1'b1, s, c, nb, fb, da, nd, st);
    n_cmp++; if ({c, s} !== e2) begin n_fail++; $display("FAIL sub2_res: got %h expected %h", {c, s}, e2); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] v;
    logic [1:0] g, e;
    int ng;
    got_q.delete();
    @(posedge clk); #1;
    start1 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      v = 3'(j);
      a1 = v[2]; b1 = v[1]; ci1 = v[0];
      exp_q.push_back(2'({1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]}));
      @(posedge clk); #1;
      if (j == 7) start1 = 1'b0;
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    ng = got_q.size();
    n_cmp++; if (ng != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", ng); end
    for (int j = 0; j < 8; j++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 2'bxx;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL b2b_res%0d: got %b expected %b", j, g, e); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0;
    test_reset();
    test_add_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid_run();
    test_start_after_reset();
    test_sub();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
